// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3/SHAKE load path: modes, FSM states,
// domain-separation bytes and the rate lookup used to size each absorb block.
package sha3_pkg;

    typedef enum logic [1:0] {
        MODE_SHAKE128 = 2'd0,
        MODE_SHAKE256 = 2'd1,
        MODE_SHA3_256 = 2'd2,
        MODE_SHA3_512 = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BUF = 2'd1,
        ST_LOAD     = 2'd2,
        ST_HANDOFF  = 2'd3
    } state_t;

    localparam logic [7:0] DS_SHAKE = 8'h1F;
    localparam logic [7:0] DS_SHA3  = 8'h06;

    // Rate of the sponge expressed in datapath words of width w bits.
    function automatic int unsigned rate_words(input mode_t mode, input int w);
        case (mode)
            MODE_SHAKE128:                return 1344 / w;
            MODE_SHAKE256, MODE_SHA3_256: return 1088 / w;
            default:                      return 576 / w;
        endcase
    endfunction

    function automatic logic [7:0] domain_byte(input mode_t mode);
        return (mode == MODE_SHAKE128 || mode == MODE_SHAKE256) ? DS_SHAKE : DS_SHA3;
    endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Combinational FIPS-202 pad inserter for one datapath word: keeps bytes below
// rem, places the domain byte at rem, clears above it, and ORs in the 0x80 terminator.
module sha3_pad_word #(
    parameter int W     = 64,
    parameter int REM_W = $clog2(W/8)
) (
    input  logic [W-1:0]     i_data,
    input  logic [REM_W-1:0] i_rem,
    input  logic             i_insert_ds,
    input  logic             i_insert_term,
    input  logic [7:0]       i_ds,
    output logic [W-1:0]     o_word
);

    localparam int NB = W / 8;

    logic [7:0] w_byte;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        o_word = '0;
        w_byte = '0;
        for (int k = 0; k < NB; k++) begin
            w_byte = i_data[8*k +: 8];
            if (i_insert_ds) begin
                if (k == int'(i_rem))
                    w_byte = i_ds;
                else if (k > int'(i_rem))
                    w_byte = '0;
            end
            // Terminator shares the top byte with DS when rem == NB-1 (0x86 / 0x9F).
            if (i_insert_term && k == NB - 1)
                w_byte = w_byte | 8'h80;
            o_word[8*k +: 8] = w_byte;
        end
    end

endmodule

// File: rtl/sha3_load_ctrl.sv
// Input-load controller: takes a header then message words, writes rate-sized
// padded blocks into the absorb buffer and hands each block to the permutation.
module sha3_load_ctrl
    import sha3_pkg::*;
#(
    parameter int W     = 64,
    parameter int LEN_W = 30,
    parameter int IDX_W = $clog2(1344/W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [W-1:0]     data_in,
    output logic             ready_out,
    output logic             cfg_valid,
    output logic [1:0]       mode_o,
    output logic [LEN_W-1:0] in_len_o,
    output logic [LEN_W-1:0] out_len_o,
    input  logic             buf_free,
    output logic             blk_we,
    output logic [IDX_W-1:0] blk_idx,
    output logic [W-1:0]     blk_word,
    output logic             blk_valid,
    output logic             blk_last,
    input  logic             blk_ready
);

    localparam int               BPW   = W / 8;
    localparam int               REM_W = $clog2(BPW);
    localparam logic [LEN_W-1:0] BPW_L = LEN_W'(BPW);

    state_t           r_state;
    mode_t            r_mode;
    logic [LEN_W-1:0] r_in_len, r_out_len, r_bytes_left;
    logic             r_pad_done, r_cfg_valid, r_out_en;
    logic [IDX_W-1:0] r_idx, r_blk_idx;
    logic             r_blk_we, r_blk_valid, r_blk_last;
    logic [W-1:0]     r_blk_word;

    logic         w_has_data, w_full, w_part, w_ready, w_xfer, w_last_idx;
    logic         w_ins_ds, w_ins_term, w_advance;
    logic [W-1:0] w_pad_data, w_pad_word;

    assign w_has_data = (r_bytes_left != '0);
    assign w_full     = (r_bytes_left >= BPW_L);
    assign w_part     = w_has_data && !w_full;
    // r_out_en keeps ready low while reset is held and until the first clock after release.
    assign w_ready    = r_out_en && (r_state == ST_IDLE || (r_state == ST_LOAD && w_has_data));
    assign w_xfer     = valid_in && w_ready;
    assign w_last_idx = (r_idx == IDX_W'(rate_words(r_mode, W) - 1));
    assign w_ins_ds   = w_part || (!w_has_data && !r_pad_done);
    assign w_ins_term = w_last_idx && (r_pad_done || w_ins_ds);
    assign w_pad_data = w_has_data ? data_in : '0;
    assign w_advance  = w_has_data ? w_xfer : 1'b1;

    sha3_pad_word #(.W(W), .REM_W(REM_W)) u_pad (
        .i_data        (w_pad_data),
        .i_rem         (r_bytes_left[REM_W-1:0]),
        .i_insert_ds   (w_ins_ds),
        .i_insert_term (w_ins_term),
        .i_ds          (domain_byte(r_mode)),
        .o_word        (w_pad_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_SHAKE128;
            r_in_len     <= '0;
            r_out_len    <= '0;
            r_bytes_left <= '0;
            r_pad_done   <= 1'b0;
            r_cfg_valid  <= 1'b0;
            r_out_en     <= 1'b0;
            r_idx        <= '0;
            r_blk_we     <= 1'b0;
            r_blk_idx    <= '0;
            r_blk_word   <= '0;
            r_blk_valid  <= 1'b0;
            r_blk_last   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_out_en    <= 1'b1;
            r_cfg_valid <= 1'b0;
            r_blk_we    <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_xfer) begin
                    r_in_len     <= data_in[LEN_W-1:0];
                    r_out_len    <= data_in[2*LEN_W-1:LEN_W];
                    r_mode       <= mode_t'(data_in[2*LEN_W +: 2]);
                    r_bytes_left <= data_in[LEN_W-1:0];
                    r_pad_done   <= 1'b0;
                    r_cfg_valid  <= 1'b1;
                    r_state      <= ST_WAIT_BUF;
                end
                ST_WAIT_BUF: if (buf_free) begin
                    r_idx   <= '0;
                    r_state <= ST_LOAD;
                end
                ST_LOAD: if (w_advance) begin
                    r_blk_we     <= 1'b1;
                    r_blk_idx    <= r_idx;
                    r_blk_word   <= w_pad_word;
                    r_bytes_left <= w_full ? (r_bytes_left - BPW_L) : '0;
                    r_pad_done   <= r_pad_done | w_ins_ds;
                    if (w_last_idx)
                        r_state <= ST_HANDOFF;
                    else
                        r_idx <= r_idx + IDX_W'(1);
                end
                ST_HANDOFF: begin
                    // First HANDOFF cycle carries the final write; valid rises after it lands.
                    if (!r_blk_valid) begin
                        r_blk_valid <= 1'b1;
                        r_blk_last  <= r_pad_done;
                    end else if (blk_ready) begin
                        r_blk_valid <= 1'b0;
                        r_blk_last  <= 1'b0;
                        r_state     <= r_blk_last ? ST_IDLE : ST_WAIT_BUF;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready_out = w_ready;
    assign cfg_valid = r_cfg_valid;
    assign mode_o    = r_mode;
    assign in_len_o  = r_in_len;
    assign out_len_o = r_out_len;
    assign blk_we    = r_blk_we;
    assign blk_idx   = r_blk_idx;
    assign blk_word  = r_blk_word;
    assign blk_valid = r_blk_valid;
    assign blk_last  = r_blk_last;

endmodule

// File: tb/tb_sha3_load_ctrl.sv
// Bench for sha3_load_ctrl: a byte-level FIPS-202 padding model fills expected
// write/block queues; negedge monitors pop and compare what the two DUTs produce.
module tb_sha3_load_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v64, rdy64, cfgv64, buf64, we64, bv64, bl64, br64;
    logic [63:0] d64, word64;
    logic [1:0]  mode64;
    logic [29:0] inl64, outl64;
    logic [4:0]  idx64;

    logic        v32, rdy32, cfgv32, buf32, we32, bv32, bl32, br32;
    logic [31:0] d32, word32;
    logic [1:0]  mode32;
    logic [13:0] inl32, outl32;
    logic [5:0]  idx32;

    sha3_load_ctrl #(.W(64), .LEN_W(30)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .valid_in(v64), .data_in(d64), .ready_out(rdy64),
        .cfg_valid(cfgv64), .mode_o(mode64), .in_len_o(inl64), .out_len_o(outl64),
        .buf_free(buf64), .blk_we(we64), .blk_idx(idx64), .blk_word(word64),
        .blk_valid(bv64), .blk_last(bl64), .blk_ready(br64)
    );

    sha3_load_ctrl #(.W(32), .LEN_W(14)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .valid_in(v32), .data_in(d32), .ready_out(rdy32),
        .cfg_valid(cfgv32), .mode_o(mode32), .in_len_o(inl32), .out_len_o(outl32),
        .buf_free(buf32), .blk_we(we32), .blk_idx(idx32), .blk_word(word32),
        .blk_valid(bv32), .blk_last(bl32), .blk_ready(br32)
    );

    typedef struct packed { logic [5:0] idx; logic [63:0] word; } wr_t;
    typedef struct packed { logic last; logic [5:0] nw; } blk_t;

    wr_t  exp_wr64[$], exp_wr32[$];
    blk_t exp_blk64[$], exp_blk32[$];
    wr_t  mon_w64, mon_w32;
    blk_t mon_b64, mon_b32;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] msg [64];
    int          wr_cnt64 = 0, wr_cnt32 = 0, cfg_cnt64 = 0, cfg_cnt32 = 0;
    int          rdy_delay = 0, buf_hold = 0, vcnt = 0, buf_lo = 0;
    bit          done64 = 1'b0, done32 = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor / responder for the 64-bit instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we64) begin
                mon_w64 = (exp_wr64.size() > 0) ? exp_wr64.pop_front() : '1;
                check("wr64_idx", 64'(idx64), 64'(mon_w64.idx));
                check("wr64_word", word64, mon_w64.word);
                wr_cnt64++;
            end
            if (cfgv64) cfg_cnt64++;
            if (bv64) begin
                if (vcnt == 0) begin
                    mon_b64 = (exp_blk64.size() > 0) ? exp_blk64.pop_front() : '1;
                    check("blk64_last", 64'(bl64), 64'(mon_b64.last));
                    check("blk64_writes", 64'(wr_cnt64), 64'(mon_b64.nw));
                    wr_cnt64 = 0;
                end else begin
                    check("handoff_ready_low", 64'(rdy64), 64'd0);
                end
                br64 = (vcnt >= rdy_delay);
                if (br64 && bl64) done64 = 1'b1;
                if (br64) buf_lo = buf_hold;
                vcnt++;
            end else begin
                br64 = 1'b0;
                vcnt = 0;
            end
            if (!buf64) check("no_write_while_buf_busy", 64'(we64), 64'd0);
            if (buf_lo > 0) begin
                buf64 = 1'b0;
                buf_lo--;
            end else begin
                buf64 = 1'b1;
            end
        end
    end

    // Monitor for the 32-bit instance (buffer always free, permutation always ready).
    always @(negedge clk) begin
        if (rst_n) begin
            if (we32) begin
                mon_w32 = (exp_wr32.size() > 0) ? exp_wr32.pop_front() : '1;
                check("wr32_idx", 64'(idx32), 64'(mon_w32.idx));
                check("wr32_word", 64'(word32), mon_w32.word);
                wr_cnt32++;
            end
            if (cfgv32) cfg_cnt32++;
            if (bv32) begin
                mon_b32 = (exp_blk32.size() > 0) ? exp_blk32.pop_front() : '1;
                check("blk32_last", 64'(bl32), 64'(mon_b32.last));
                check("blk32_writes", 64'(wr_cnt32), 64'(mon_b32.nw));
                wr_cnt32 = 0;
                if (bl32) done32 = 1'b1;
            end
        end
    end

    // Reference padding: message bytes, DS at in_len, 0x80 ORed into the last rate byte.
    task automatic build_exp(input int mode, input int in_len, input bit sel32);
        int          bpw, rbits, rw, rb, nblk, total;
        logic [7:0]  pb [];
        logic [63:0] src;
        wr_t         e;
        blk_t        b;
        bpw   = sel32 ? 4 : 8;
        rbits = (mode == 0) ? 1344 : (mode == 3) ? 576 : 1088;
        rw    = rbits / (bpw * 8);
        rb    = rw * bpw;
        nblk  = in_len / rb + 1;
        total = nblk * rb;
        pb = new[total];
        for (int j = 0; j < total; j++) pb[j] = 8'h00;
        for (int j = 0; j < in_len; j++) begin
            src   = msg[j / bpw];
            pb[j] = src[8*(j % bpw) +: 8];
        end
        pb[in_len]    = (mode < 2) ? 8'h1F : 8'h06;
        pb[total-1]   = pb[total-1] | 8'h80;
        for (int w = 0; w < total / bpw; w++) begin
            e.idx  = 6'(w % rw);
            e.word = '0;
            for (int k = 0; k < bpw; k++) e.word[8*k +: 8] = pb[w*bpw + k];
            if (sel32) exp_wr32.push_back(e); else exp_wr64.push_back(e);
        end
        for (int k = 0; k < nblk; k++) begin
            b.last = (k == nblk - 1);
            b.nw   = 6'(rw);
            if (sel32) exp_blk32.push_back(b); else exp_blk64.push_back(b);
        end
    endtask

    task automatic drive(input bit v, input logic [63:0] d, input bit sel32);
        v64 = v && !sel32;
        d64 = d;
        v32 = v && sel32;
        d32 = d[31:0];
    endtask

    function automatic logic rdy(input bit sel32);
        return sel32 ? rdy32 : rdy64;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(rdy64), 64'd0);
        check({tag, "_ctrl"}, {58'd0, cfgv64, we64, bv64, bl64, mode64}, 64'd0);
        check({tag, "_lens"}, {4'd0, inl64, outl64}, 64'd0);
        check({tag, "_idx"}, 64'(idx64), 64'd0);
        check({tag, "_word"}, word64, 64'd0);
        check({tag, "_ready32"}, 64'(rdy32), 64'd0);
    endtask

    task automatic send_msg(input int mode, input int in_len, input bit sel32,
                            input bit rand_v, input int abort_after);
        int          bpw, len_w, nw, i, guard, out_len;
        bit          v;
        logic [63:0] hdr;
        bpw     = sel32 ? 4 : 8;
        len_w   = sel32 ? 14 : 30;
        nw      = (in_len + bpw - 1) / bpw;
        out_len = 100 + mode;
        for (int k = 0; k < 64; k++) msg[k] = {$urandom, $urandom};
        build_exp(mode, in_len, sel32);
        done64 = 1'b0; done32 = 1'b0; cfg_cnt64 = 0; cfg_cnt32 = 0;
        hdr = (64'(mode) << (2*len_w)) | (64'(out_len) << len_w) | 64'(in_len);

        guard = 0;
        do begin
            @(negedge clk);
            drive(1'b1, hdr, sel32);
            guard++;
        end while (!rdy(sel32) && guard < 100);
        check("hdr_accepted", 64'(rdy(sel32)), 64'd1);
        @(negedge clk);
        drive(1'b0, 64'd0, sel32);
        check("cfg_valid", 64'(sel32 ? cfgv32 : cfgv64), 64'd1);
        check("cfg_mode", 64'(sel32 ? mode32 : mode64), 64'(mode));
        check("cfg_in_len", sel32 ? 64'(inl32) : 64'(inl64), 64'(in_len));
        check("cfg_out_len", sel32 ? 64'(outl32) : 64'(outl64), 64'(out_len));

        i = 0; guard = 0;
        while (i < nw && guard < 2000) begin
            if (i == abort_after) begin
                drive(1'b0, 64'd0, sel32);
                return;
            end
            v = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
            drive(v, msg[i], sel32);
            if (v && rdy(sel32)) i++;
            @(negedge clk);
            guard++;
        end
        check("msg_words_accepted", 64'(i), 64'(nw));

        // Offer surplus data until the last block is taken: none of it may be consumed.
        guard = 0;
        while (!(sel32 ? done32 : done64) && guard < 2000) begin
            drive(1'b1, 64'hDEAD_BEEF_0BAD_F00D, sel32);
            check("no_excess_consume", 64'(rdy(sel32)), 64'd0);
            @(negedge clk);
            guard++;
        end
        drive(1'b0, 64'd0, sel32);
        check("last_block_seen", 64'(sel32 ? done32 : done64), 64'd1);
        check("cfg_pulse_count", 64'(sel32 ? cfg_cnt32 : cfg_cnt64), 64'd1);
        @(negedge clk);
        check("back_to_idle_ready", 64'(rdy(sel32)), 64'd1);
        check("writes_outstanding", 64'(sel32 ? exp_wr32.size() : exp_wr64.size()), 64'd0);
        check("blocks_outstanding", 64'(sel32 ? exp_blk32.size() : exp_blk64.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 64'd0, 1'b0);
        buf64 = 1'b1; br64 = 1'b0; buf32 = 1'b1; br32 = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(rdy64), 64'd1);

        send_msg(0, 0, 1'b0, 1'b0, -1);     // SHAKE128 pad-only block
        send_msg(2, 135, 1'b0, 1'b1, -1);   // SHA3-256, DS and terminator share byte 7
        buf_hold = 5; rdy_delay = 10;
        send_msg(1, 136, 1'b0, 1'b0, -1);   // SHAKE256 exact rate, extra pad block
        buf_hold = 0; rdy_delay = 0;
        send_msg(3, 71, 1'b0, 1'b1, -1);    // SHA3-512, 0x86 in final byte
        send_msg(0, 167, 1'b0, 1'b0, -1);   // SHAKE128, 0x9F in final byte
        send_msg(3, 4, 1'b1, 1'b0, -1);     // W=32 SHA3-512

        // Reset in the middle of a block: outputs clear at once, no block issued.
        send_msg(1, 136, 1'b0, 1'b0, 5);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_load_reset");
        exp_wr64.delete(); exp_blk64.delete();
        wr_cnt64 = 0; vcnt = 0; buf_lo = 0; br64 = 1'b0; buf64 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", 64'(rdy64), 64'd1);
        send_msg(2, 20, 1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
